// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM state type and command-format constants for the SPI register-file slave.
package spi_regfile_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;
    localparam int CMD_W = 8;
    localparam int RW_BIT = 7;
    localparam int CNT_W = 6;
endpackage

// File: rtl/spi_regfile_slave_sync_edge.sv
// sync_edge: 2-flop synchroniser plus a third flop for rise/fall detection on the synchronised level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] s_q;
    always_ff @(posedge clk_i) s_q <= rst_i ? {3{RST_VAL}} : {s_q[1:0], d_i};
    assign q_o = s_q[1];
    assign rise_o = s_q[1] & ~s_q[2];
    assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-0 slave giving burst read/write access to a flat register file.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       spi_sck_i,
    input  logic                       spi_cs_i,
    input  logic                       spi_pico_i,
    output logic                       spi_poci_o,
    output logic                       spi_poci_oeb_o,
    output logic [NUM_REGS*DATA_W-1:0] reg_q_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o
);
    if (ADDR_W < 1 || ADDR_W > 7 || NUM_REGS < 2 || NUM_REGS > 2**ADDR_W || DATA_W < 8 || DATA_W > 32) begin : g_param_check
        $error("spi_regfile_slave: illegal parameter combination");
    end
    logic sck_rise, sck_fall, sck_q_unused;
    logic cs_s, cs_fall, cs_rise_unused;
    logic pico_s, pico_rise_unused, pico_fall_unused;
    sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(spi_sck_i),
        .q_o(sck_q_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(spi_cs_i),
        .q_o(cs_s), .rise_o(cs_rise_unused), .fall_o(cs_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_pico (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(spi_pico_i),
        .q_o(pico_s), .rise_o(pico_rise_unused), .fall_o(pico_fall_unused)
    );
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q, waddr_d, cmd_addr, ptr_nx;
    logic [DATA_W-1:0] sh_q, sh_d, out_q, out_d, word, rd_cmd, rd_nx;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic rw_q, rw_d, stb_q, stb_d, armed_q, armed_d, ptr_ok;
    logic [1:0] flush_q, flush_d;
    assign word = {sh_q[DATA_W-2:0], pico_s};
    assign cmd_addr = word[ADDR_W-1:0];
    assign ptr_nx = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_ok = int'(ptr_q) < NUM_REGS;
    assign rd_cmd = (int'(cmd_addr) < NUM_REGS) ? regs_q[cmd_addr] : '0;
    assign rd_nx = (int'(ptr_nx) < NUM_REGS) ? regs_q[ptr_nx] : '0;
    // Only arm once cs is seen high after the synchroniser has flushed its reset value.
    assign flush_d = (flush_q == 2'd3) ? flush_q : flush_q + 1'b1;
    assign armed_d = armed_q | (cs_s & (flush_q == 2'd3));
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        rw_d = rw_q;
        sh_d = sh_q;
        out_d = out_q;
        regs_d = regs_q;
        stb_d = 1'b0;
        waddr_d = waddr_q;
        if (cs_s) begin
            state_d = ST_IDLE;
            cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall && armed_q) begin
                    state_d = ST_CMD;
                    cnt_d = '0;
                end
                ST_CMD: if (sck_rise) begin
                    sh_d = word;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CMD_W - 1)) begin
                        state_d = ST_DATA;
                        cnt_d = '0;
                        ptr_d = cmd_addr;
                        rw_d = word[RW_BIT];
                        out_d = rd_cmd;
                    end
                end
                ST_DATA: if (sck_rise) begin
                    sh_d = word;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
                        ptr_d = ptr_nx;
                        out_d = rd_nx;
                        if (rw_q && ptr_ok) begin
                            regs_d[ptr_q] = word;
                            stb_d = 1'b1;
                            waddr_d = ptr_q;
                        end
                    end
                end else if (sck_fall && cnt_q != '0) begin
                    // The fall right after a reload keeps the fresh MSB on the line.
                    out_d = {out_q[DATA_W-2:0], 1'b0};
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            ptr_q <= '0;
            rw_q <= 1'b0;
            sh_q <= '0;
            out_q <= '0;
            regs_q <= '{default: '0};
            stb_q <= 1'b0;
            waddr_q <= '0;
            armed_q <= 1'b0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            rw_q <= rw_d;
            sh_q <= sh_d;
            out_q <= out_d;
            regs_q <= regs_d;
            stb_q <= stb_d;
            waddr_q <= waddr_d;
            armed_q <= armed_d;
            flush_q <= flush_d;
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q_o[g*DATA_W +: DATA_W] = regs_q[g];
    end
    assign spi_poci_oeb_o = !(state_q == ST_DATA && !rw_q && !cs_s);
    assign spi_poci_o = !spi_poci_oeb_o & out_q[DATA_W-1];
    assign wr_strobe_o = stb_q;
    assign wr_addr_o = waddr_q;
endmodule
